gpr_write_arbiter: RTL and testbench
====================================

// Module: gpr_write_arbiter
// PURPOSE
//  Shares the single write port of gp_registers between NREQ writeback requesters
//  (default ALU, load unit, immediate loader). Drives write_enable, select_reg and
//  write data into gp_registers from registered outputs.
//  Keeps a per-register busy scoreboard. Issue logic reserves a destination register;
//  the reservation clears when that register's write lands. Decode stalls on busy sources.
// PARAMETERS
//  NREQ    3   number of writeback requesters; index 0 = ALU, 1 = LOAD, 2 = IMM
//  DATA_W  16  register data width
//  NREGS   4   number of GPRs (A..D)
//  REG_AW  2   register index width, equal to clog2(NREGS)
// PORTS
//  clk           in   1            system clock, rising edge
//  reset         in   1            asynchronous, active-high reset
//  req_valid     in   NREQ         requester i has a write pending
//  req_reg       in   NREQ*REG_AW  destination index per requester; slice i at [i*REG_AW +: REG_AW]
//  req_data      in   NREQ*DATA_W  write data per requester; slice i at [i*DATA_W +: DATA_W]
//  req_ready     out  NREQ         one-hot grant; combinational from req_valid and arbiter state
//  rsv_valid     in   1            issue logic reserves register rsv_reg
//  rsv_reg       in   REG_AW       register being reserved
//  rsv_ready     out  1            reservation accepted this cycle; equals ~busy[rsv_reg]
//  busy          out  NREGS        scoreboard; bit r = 1 while a write to r is outstanding
//  write_enable  out  1            to gp_registers.write_enable
//  select_reg    out  REG_AW       to gp_registers.select_reg
//  gpr_data      out  DATA_W       to gp_registers.alu_result
// BEHAVIOUR
//  Reset (asynchronous, any cycle):
//   - write_enable=0, select_reg=0, gpr_data=0, busy=0.
//   - Arbiter pointer=0. Any in-flight granted write is dropped.
//   - req_ready=0 and rsv_ready=0 while reset is high.
//  Handshake:
//   - A transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
//   - Requesters hold req_valid, req_reg and req_data stable until granted. Dropping valid early is illegal.
//   - At most one req_ready bit is high per cycle. req_ready=0 whenever req_valid=0.
//  Arbitration (default, fixed priority): lowest valid index wins.
//  Latency:
//   - Grant in cycle N; write_enable=1 with select_reg/gpr_data set during cycle N+1.
//   - gp_registers captures at the N+1/N+2 edge.
//   - Back-to-back grants give one write per cycle, full throughput.
//  No grant: write_enable=0 next cycle; select_reg and gpr_data hold their last values.
//  Scoreboard:
//   - rsv_valid & rsv_ready at an edge sets busy[rsv_reg].
//   - An edge where write_enable=1 clears busy[select_reg], so the clear coincides with the register update.
//   - Set on a not-busy reg and clear on a different reg in the same cycle: both take effect.
//   - Reserving a reg that is busy, including one whose write is landing this cycle, is refused (rsv_ready=0).
//   - Writes to non-busy registers are legal and leave busy unchanged.
//  Two requesters may target the same register. Order is arbitration order; the last write wins.
// CONFIGURATION
//  Macro GPR_ARB_RR_EN.
//   - Defined: round-robin. A pointer names the highest-priority index. After a grant to i,
//     the pointer becomes (i+1) mod NREQ; with no grant it holds. Reset sets the pointer to 0.
//   - Undefined: fixed priority as above. No pointer register is built.
// STRUCTURE
//  Package vr16_pkg:
//   - DATA_W, NREGS, REG_AW constants.
//   - Register-index constants REG_A=0 .. REG_D=3.
//   - Requester-index constants WB_ALU=0, WB_LOAD=1, WB_IMM=2.
//  Sub-module gpr_wb_pick:
//   - Combinational one-hot picker with inputs valid and pointer; outputs grant and the encoded index.
//   - The pointer input is tied to 0 when GPR_ARB_RR_EN is undefined.
//  Top level holds the output registers, the busy register and the optional pointer register.
// TESTING
//  1. Reset mid-write: grant ALU (reg B, 16'h1111), assert reset before N+1 -> write_enable=0, busy=0, reg B unchanged.
//  2. Single write: ALU req reg A data 16'h1111 -> req_ready=3'b001 in cycle N; write_enable=1, select_reg=0 in N+1; reg_a_out=16'h1111 after.
//  3. Contention: all three valid to C/D/A -> without the macro, grants ALU, LOAD, IMM over 3 consecutive cycles.
//     With GPR_ARB_RR_EN, ALU and LOAD held valid continuously -> grants alternate 001, 010, 001.
//  4. Scoreboard: reserve D -> busy=4'b1000, rsv_ready for D=0. LOAD writes D -> busy clears on the write edge. Re-reserve D accepted next cycle.
//  5. Simultaneous events: reserve A while a write to C lands -> busy goes A=1, C=0 in one edge.
//     Reserving C in that same cycle -> rsv_ready=0.
//  6. Same-target race: ALU and IMM both write reg B (16'hAAAA, 16'h5555) -> reg_b_out ends with the later-granted value.

Source files
------------

// File: rtl/vr16_pkg.sv
// vr16_pkg: shared sizes and index constants for the vr16 GPR writeback path.
package vr16_pkg;
    localparam int DATA_W = 16;
    localparam int NREGS  = 4;
    localparam int REG_AW = 2;
    localparam logic [REG_AW-1:0] REG_A = 2'd0;
    localparam logic [REG_AW-1:0] REG_B = 2'd1;
    localparam logic [REG_AW-1:0] REG_C = 2'd2;
    localparam logic [REG_AW-1:0] REG_D = 2'd3;
    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_IMM  = 2;
endpackage

// File: rtl/gpr_write_arbiter_if.sv
// gpr_wb_if: writeback requests, reservations and the GPR write port.
interface gpr_wb_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = vr16_pkg::DATA_W,
    parameter int NREGS  = vr16_pkg::NREGS,
    parameter int REG_AW = vr16_pkg::REG_AW
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*REG_AW-1:0] req_reg;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   rsv_valid;
    logic [REG_AW-1:0]      rsv_reg;
    logic                   rsv_ready;
    logic [NREGS-1:0]       busy;
    logic                   write_enable;
    logic [REG_AW-1:0]      select_reg;
    logic [DATA_W-1:0]      gpr_data;
    modport master (
        output req_valid, req_reg, req_data, rsv_valid, rsv_reg,
        input  req_ready, rsv_ready, busy, write_enable, select_reg, gpr_data
    );
    modport slave (
        input  req_valid, req_reg, req_data, rsv_valid, rsv_reg,
        output req_ready, rsv_ready, busy, write_enable, select_reg, gpr_data
    );
endinterface

// File: rtl/gpr_write_arbiter_pick.sv
// gpr_wb_pick: one-hot picker; the first valid index at or after pointer wins.
module gpr_wb_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);
    always_comb begin
        int j;
        j = 0;
        grant = '0;
        index = '0;
        // walk from lowest to highest priority so the last hit is the winner
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(pointer) + k) % N;
            if (valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                index    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/gpr_write_arbiter.sv
// gpr_write_arbiter: shares the GPR write port among writeback requesters and keeps a busy scoreboard.
// Define GPR_ARB_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module gpr_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = vr16_pkg::DATA_W,
    parameter int NREGS  = vr16_pkg::NREGS,
    parameter int REG_AW = vr16_pkg::REG_AW
) (
    input logic     clk,
    input logic     reset,
    gpr_wb_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     idx;
    logic              we;
    logic [REG_AW-1:0] sel;
    logic [DATA_W-1:0] data;
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  set_mask;
    logic [NREGS-1:0]  clr_mask;
    gpr_wb_pick #(.N(NREQ), .IW(IW)) u_pick (
        .valid  (bus.req_valid),
        .pointer(ptr),
        .grant  (grant),
        .index  (idx)
    );
`ifdef GPR_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr <= '0;
        else if (|grant) ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    end
`else
    assign ptr = '0;
`endif
    assign bus.req_ready = reset ? '0 : grant;
    assign bus.rsv_ready = ~reset & ~busy[bus.rsv_reg];
    // the clear lands on the same edge gp_registers captures the write
    always_comb begin
        set_mask = (bus.rsv_valid && bus.rsv_ready) ? NREGS'(1) << bus.rsv_reg : '0;
        clr_mask = we ? NREGS'(1) << sel : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we   <= 1'b0;
            sel  <= '0;
            data <= '0;
            busy <= '0;
        end else begin
            we   <= |grant;
            busy <= (busy & ~clr_mask) | set_mask;
            if (|grant) begin
                sel  <= bus.req_reg[idx*REG_AW +: REG_AW];
                data <= bus.req_data[idx*DATA_W +: DATA_W];
            end
        end
    end
    assign bus.write_enable = we;
    assign bus.select_reg   = sel;
    assign bus.gpr_data     = data;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_gpr_write_arbiter.sv
// tb_gpr_write_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_gpr_write_arbiter;
    import vr16_pkg::*;
    localparam int NR = 3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    gpr_wb_if #(.NREQ(NR), .DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) bus ();
    gpr_write_arbiter #(.NREQ(NR), .DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    logic [NR-1:0] v = '0;
    logic [NR-1:0] hold = '0;
    logic [1:0]    r [NR];
    logic [15:0]   d [NR];
    int n_cmp = 0;
    int n_fail = 0;
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]           = v[i];
            bus.req_reg[i*2 +: 2]      = r[i];
            bus.req_data[i*16 +: 16]   = d[i];
        end
    end
    // stand-in for gp_registers, fed only by the DUT outputs
    logic [15:0] rf_dut [4] = '{default: '0};
    always @(posedge clk) if (bus.write_enable) rf_dut[bus.select_reg] <= bus.gpr_data;
    logic        m_we;
    logic [1:0]  m_sel;
    logic [15:0] m_data;
    logic [3:0]  m_busy;
    int          m_ptr;
    logic [15:0] m_rf [4] = '{default: '0};
    function automatic int exp_idx();
        if (reset) return -1;
        for (int k = 0; k < NR; k++) if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        return -1;
    endfunction
    function automatic logic [3:0] next_busy();
        logic [3:0] b;
        for (int q = 0; q < 4; q++) begin
            b[q] = m_busy[q] && !(m_we && m_sel == 2'(q));
            if (bus.rsv_valid && bus.rsv_reg == 2'(q) && !m_busy[q]) b[q] = 1'b1;
        end
        return b;
    endfunction
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_we <= 1'b0; m_sel <= '0; m_data <= '0; m_busy <= '0; m_ptr <= 0;
        end else begin
            if (m_we) m_rf[m_sel] <= m_data;
            m_busy <= next_busy();
            m_we   <= exp_idx() >= 0;
            if (exp_idx() >= 0) begin
                m_sel  <= r[exp_idx()];
                m_data <= d[exp_idx()];
`ifdef GPR_ARB_RR_EN
                m_ptr  <= (exp_idx() + 1) % NR;
`endif
            end
        end
    end
    function automatic logic [26:0] exp_vec();
        int g;
        logic [2:0] rdy;
        g = exp_idx();
        rdy = (g < 0) ? 3'b000 : 3'(1 << g);
        return {rdy, !reset && !m_busy[bus.rsv_reg], m_busy, m_we, m_sel, m_data};
    endfunction
    function automatic logic [26:0] obs_vec();
        return {bus.req_ready, bus.rsv_ready, bus.busy, bus.write_enable, bus.select_reg, bus.gpr_data};
    endfunction
    task automatic cyc();
        int g;
        g = exp_idx();
        @(posedge clk);
        @(negedge clk);
        if (g >= 0 && !hold[g]) v[g] = 1'b0;
    endtask
    task automatic test_reset();
        #1;
        n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec()); end
        n_cmp++; if ({bus.write_enable, bus.busy, bus.select_reg, bus.gpr_data} !== 23'd0) begin n_fail++; $display("FAIL reset_zero: got %h want 0", {bus.write_enable, bus.busy, bus.select_reg, bus.gpr_data}); end
        v = 3'b001;
        #1;
        n_cmp++; if ({bus.req_ready, bus.rsv_ready} !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", {bus.req_ready, bus.rsv_ready}); end
        v = '0;
        reset = 1'b0;
    endtask
    task automatic test_reset_mid_write();
        @(negedge clk);
        v[WB_ALU] = 1'b1; r[WB_ALU] = REG_B; d[WB_ALU] = 16'h1111;
        #1;
        n_cmp++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL midrst_grant: got %b want 001", bus.req_ready); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL midrst_ready: got %b want 000", bus.req_ready); end
        v = '0;
        @(negedge clk);
        #1;
        n_cmp++; if ({bus.write_enable, bus.busy} !== 5'b0) begin n_fail++; $display("FAIL midrst_we_busy: got %b want 00000", {bus.write_enable, bus.busy}); end
        reset = 1'b0;
        cyc(); cyc();
        #1;
        n_cmp++; if (rf_dut[REG_B] !== 16'h0000) begin n_fail++; $display("FAIL midrst_regb: got %h want 0000", rf_dut[REG_B]); end
    endtask
    task automatic test_single();
        @(negedge clk);
        v[WB_ALU] = 1'b1; r[WB_ALU] = REG_A; d[WB_ALU] = 16'h1111;
        #1;
        n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL single_n: got %h want %h", obs_vec(), exp_vec()); end
        n_cmp++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready: got %b want 001", bus.req_ready); end
        cyc();
        #1;
        n_cmp++; if ({bus.write_enable, bus.select_reg, bus.gpr_data} !== {1'b1, REG_A, 16'h1111}) begin n_fail++; $display("FAIL single_write: got %h want %h", {bus.write_enable, bus.select_reg, bus.gpr_data}, {1'b1, REG_A, 16'h1111}); end
        cyc();
        #1;
        n_cmp++; if (rf_dut[REG_A] !== 16'h1111) begin n_fail++; $display("FAIL single_rega: got %h want 1111", rf_dut[REG_A]); end
        n_cmp++; if (bus.write_enable !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", bus.write_enable); end
    endtask
    task automatic test_contention();
        logic [2:0] first;
        @(negedge clk);
        v = 3'b111;
        r[0] = REG_C; d[0] = 16'hC0C0;
        r[1] = REG_D; d[1] = 16'hD0D0;
        r[2] = REG_A; d[2] = 16'hA0A0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL contend_%0d: got %h want %h", k, obs_vec(), exp_vec()); end
`ifndef GPR_ARB_RR_EN
            if (k < 3) begin
                n_cmp++; if (bus.req_ready !== 3'(1 << k)) begin n_fail++; $display("FAIL contend_order_%0d: got %b want %b", k, bus.req_ready, 3'(1 << k)); end
            end
`endif
            cyc();
        end
        hold = 3'b011;
        v = 3'b011;
        first = exp_vec()[26:24];
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL hold_%0d: got %h want %h", k, obs_vec(), exp_vec()); end
`ifdef GPR_ARB_RR_EN
            n_cmp++; if (bus.req_ready !== ((k % 2 == 0) ? first : (first ^ 3'b011))) begin n_fail++; $display("FAIL rr_alt_%0d: got %b want %b", k, bus.req_ready, (k % 2 == 0) ? first : (first ^ 3'b011)); end
`else
            n_cmp++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL fixed_hold_%0d: got %b want 001", k, bus.req_ready); end
`endif
            cyc();
        end
        hold = '0;
        v = '0;
        cyc(); cyc();
    endtask
    task automatic test_scoreboard();
        @(negedge clk);
        bus.rsv_valid = 1'b1; bus.rsv_reg = REG_D;
        #1;
        n_cmp++; if (bus.rsv_ready !== 1'b1) begin n_fail++; $display("FAIL sb_rsv_ok: got %b want 1", bus.rsv_ready); end
        cyc();
        #1;
        n_cmp++; if ({bus.busy, bus.rsv_ready} !== 5'b1000_0) begin n_fail++; $display("FAIL sb_busy_d: got %b want 10000", {bus.busy, bus.rsv_ready}); end
        bus.rsv_valid = 1'b0;
        v[WB_LOAD] = 1'b1; r[WB_LOAD] = REG_D; d[WB_LOAD] = 16'h2222;
        cyc();
        #1;
        n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL sb_landing: got %h want %h", obs_vec(), exp_vec()); end
        n_cmp++; if (bus.busy !== 4'b1000) begin n_fail++; $display("FAIL sb_busy_hold: got %b want 1000", bus.busy); end
        cyc();
        #1;
        n_cmp++; if (bus.busy !== 4'b0000) begin n_fail++; $display("FAIL sb_busy_clr: got %b want 0000", bus.busy); end
        bus.rsv_valid = 1'b1; bus.rsv_reg = REG_D;
        #1;
        n_cmp++; if (bus.rsv_ready !== 1'b1) begin n_fail++; $display("FAIL sb_rersv: got %b want 1", bus.rsv_ready); end
        cyc();
        bus.rsv_valid = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 4'b1000) begin n_fail++; $display("FAIL sb_busy_again: got %b want 1000", bus.busy); end
        v[WB_IMM] = 1'b1; r[WB_IMM] = REG_D; d[WB_IMM] = 16'h4444;
        cyc(); cyc();
        #1;
        n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL sb_final: got %h want %h", obs_vec(), exp_vec()); end
    endtask
    task automatic test_simultaneous();
        @(negedge clk);
        bus.rsv_valid = 1'b1; bus.rsv_reg = REG_C;
        cyc();
        bus.rsv_valid = 1'b0;
        v[WB_ALU] = 1'b1; r[WB_ALU] = REG_C; d[WB_ALU] = 16'h3333;
        cyc();
        bus.rsv_valid = 1'b1; bus.rsv_reg = REG_C;
        #1;
        n_cmp++; if (bus.rsv_ready !== 1'b0) begin n_fail++; $display("FAIL sim_rsv_landing: got %b want 0", bus.rsv_ready); end
        bus.rsv_reg = REG_A;
        #1;
        n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL sim_vec: got %h want %h", obs_vec(), exp_vec()); end
        cyc();
        bus.rsv_valid = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 4'b0001) begin n_fail++; $display("FAIL sim_busy: got %b want 0001", bus.busy); end
        v[WB_LOAD] = 1'b1; r[WB_LOAD] = REG_A; d[WB_LOAD] = 16'h0005;
        cyc(); cyc();
        #1;
        n_cmp++; if (bus.busy !== 4'b0000) begin n_fail++; $display("FAIL sim_clear: got %b want 0000", bus.busy); end
    endtask
    task automatic test_same_target();
        @(negedge clk);
        v[WB_ALU] = 1'b1; r[WB_ALU] = REG_B; d[WB_ALU] = 16'hAAAA;
        v[WB_IMM] = 1'b1; r[WB_IMM] = REG_B; d[WB_IMM] = 16'h5555;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL race_%0d: got %h want %h", k, obs_vec(), exp_vec()); end
            cyc();
        end
        #1;
        n_cmp++; if (rf_dut[REG_B] !== m_rf[REG_B]) begin n_fail++; $display("FAIL race_regb: got %h want %h", rf_dut[REG_B], m_rf[REG_B]); end
`ifndef GPR_ARB_RR_EN
        n_cmp++; if (rf_dut[REG_B] !== 16'h5555) begin n_fail++; $display("FAIL race_last: got %h want 5555", rf_dut[REG_B]); end
`endif
    endtask
    task automatic test_random();
        @(negedge clk);
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v[i] && $urandom_range(2) == 0) begin
                    v[i] = 1'b1;
                    r[i] = 2'($urandom_range(3));
                    d[i] = 16'($urandom);
                end
            end
            bus.rsv_valid = 1'($urandom_range(1));
            bus.rsv_reg   = 2'($urandom_range(3));
            #1;
            n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL rand_%0d: got %h want %h", k, obs_vec(), exp_vec()); end
            if (k == 150) begin
                reset = 1'b1;
                #1;
                n_cmp++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL rand_reset: got %h want %h", obs_vec(), exp_vec()); end
                v = '0;
                #1 reset = 1'b0;
            end
            cyc();
        end
        bus.rsv_valid = 1'b0;
        for (int k = 0; k < 8 && v != '0; k++) cyc();
        cyc(); cyc();
        #1;
        for (int q = 0; q < 4; q++) begin
            n_cmp++; if (rf_dut[q] !== m_rf[q]) begin n_fail++; $display("FAIL rand_rf_%0d: got %h want %h", q, rf_dut[q], m_rf[q]); end
        end
    endtask
    initial begin
        for (int i = 0; i < NR; i++) begin r[i] = '0; d[i] = '0; end
        bus.rsv_valid = 1'b0;
        bus.rsv_reg = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_reset_mid_write();
        test_single();
        test_contention();
        test_scoreboard();
        test_simultaneous();
        test_same_target();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
